pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised elastic pipeline stage that replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries an opaque packed payload, typically `$bits(idex_reg_t)` and the like, with valid/ready handshakes on both sides. Storage depth is configurable and a synchronous flush supports branch, exception and fence.i recovery. It sits between every pair of core pipeline stages, so back-pressure is fully registered and no combinational ready path crosses stages.

## Interface
- `Width`, default 32: payload bits; any value ≥1.
- `Depth`, default 2: storage entries; ≥1. Depth=1 is a half-throughput register. Depth≥2 gives full throughput.
- `ResetPayload`, default `'0`: value loaded into every entry at reset.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  synchronous discard of all held and incoming entries.
- `in_valid_i`  in  1  upstream entry valid.
- `in_ready_o`  out  1  space available; registered-state function only.
- `in_data_i`  in  Width  upstream payload.
- `out_valid_o`  out  1  head entry valid.
- `out_ready_i`  in  1  downstream accepts head.
- `out_data_o`  out  Width  head payload, driven from storage (no path from `in_data_i`).
- `count_o`  out  $clog2(Depth+1)  occupied entries.

## Operation
- Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(Depth) bits (minimum 1), plus `count`.
- Pointers increment modulo Depth. At Depth-1 a pointer wraps to 0, including non-power-of-2 depths.
- push = `in_valid_i & in_ready_o & ~flush_i`; pop = `out_valid_o & out_ready_i & ~flush_i`.
- `in_ready_o = (count != Depth)`. When full it stays 0 even if `out_ready_i`=1 that cycle; no ready_i→ready_o combinational path.
- `out_valid_o = (count != 0)`; `out_data_o = mem[rd_ptr]`.
- Push only: write `mem[wr_ptr]`, wr_ptr++, count++. Pop only: rd_ptr++, count--.
- Push and pop together (not full, not empty): both pointers advance and count is unchanged.
- Push into an empty buffer becomes visible at the output the next cycle; there is no fall-through.
- `flush_i` has top priority. Next cycle: count=0, rd_ptr=wr_ptr=0, `out_valid_o`=0. A concurrent push or pop is ignored. Storage contents are not cleared.
- Payload is never inspected or modified. Once accepted, `out_data_o` stays stable while `out_valid_o`=1 and `out_ready_i`=0.
- Upstream must hold `in_data_i` stable while `in_valid_i`=1 and `in_ready_o`=0. The block does not check this.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, all entries=ResetPayload. Outputs: `out_valid_o`=0, `in_ready_o`=1, `out_data_o`=ResetPayload, `count_o`=0.
- Latency: accept at edge N, presented at N+1.
- Throughput: Depth≥2 sustains 1 transfer/cycle when downstream is always ready. Depth=1 sustains 1 transfer per 2 cycles.
- Full with simultaneous pop: `in_ready_o`=1 one cycle after the pop edge.
- Empty with `out_ready_i`=1: no pop, no pointer change.
- Reset asserted mid-transfer: all held entries are lost immediately and outputs take their reset values asynchronously.

## Structure
- Stage payload structs (`idex_reg_t`, `exmem_reg_t`, `memwb_reg_t`) stay in the pipeline package.
- Add to that package one localparam per stage giving its buffer depth, so depths are tuned in one place.
- The instantiating stage sets Width via `$bits(<struct>)` and casts the payload on both sides.
- One sub-module is natural: `pipe_wrap_ctr`, a modulo-Depth pointer with an increment enable and a synchronous clear. Instantiate it twice, for rd and wr.

## Test plan
- Reset release, Depth=2, Width=8: `in_ready_o`=1, `out_valid_o`=0, `count_o`=0, `out_data_o`=0x00.
- Streaming: push 0x11,0x22,0x33 on consecutive cycles with `out_ready_i`=1.
  - Outputs appear 1 cycle later in order.
  - `count_o` stays 1 and `in_ready_o` stays 1 throughout.
- Back-pressure: Depth=3, `out_ready_i`=0, push 0xA1..0xA4.
  - 0xA1..0xA3 are accepted; `in_ready_o`=0 after the third, so 0xA4 is held upstream; `count_o`=3.
  - Then set `out_ready_i`=1 and keep `in_valid_i`=1 with 0xA4. Outputs are 0xA1,0xA2,0xA3,0xA4, each consumed once and none duplicated.
  - `rd_ptr` wraps 2→0.
- Full with simultaneous pop: Depth=2 full with 0x01,0x02, `out_ready_i`=1, `in_valid_i`=1 with 0x03.
  - 0x03 is rejected that cycle because `in_ready_o`=0.
  - It is accepted the next cycle; output order is 0x01,0x02,0x03.
- Flush: holding 2 entries, assert `flush_i` with `in_valid_i`=1 (0x55) and `out_ready_i`=1.
  - Next cycle `count_o`=0 and `out_valid_o`=0; 0x55 never appears.
  - A subsequent push 0x66 is output next.
- Reset mid-operation: Depth=4 holding 3 entries, pulse `rst_ni` low between edges.
  - Outputs go to reset values immediately with no clock edge.
  - After release, the first push 0x77 is the first output.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline types and per-stage elastic buffer depths.
// Stage payloads travel through pipe_stage_buf as opaque packed bits.
package pipe_stage_buf_pkg;

    localparam int unsigned XLEN = 32;

    // Per-stage buffer depths, tuned here only.
    localparam int unsigned IFID_DEPTH  = 2;
    localparam int unsigned IDEX_DEPTH  = 2;
    localparam int unsigned EXMEM_DEPTH = 2;
    localparam int unsigned MEMWB_DEPTH = 2;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC4  = 2'd3
    } wb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ifid_reg_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [3:0]      alu_op;
        logic            mem_rd;
        logic            mem_wr;
        wb_sel_e         wb_sel;
    } idex_reg_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] st_data;
        logic [4:0]      rd;
        logic            mem_rd;
        logic            mem_wr;
        wb_sel_e         wb_sel;
    } exmem_reg_t;

    typedef struct packed {
        logic [XLEN-1:0] wb_data;
        logic [4:0]      rd;
        logic            wb_en;
    } memwb_reg_t;

    // Pointer width for a modulo-d index, never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned d);
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/pipe_stage_buf_wrap_ctr.sv
// Modulo-Depth pointer with increment enable and synchronous clear.
// Wraps from Depth-1 to 0 for any depth, power of two or not.
module pipe_wrap_ctr #(
    parameter int unsigned Depth = 2,
    parameter int unsigned PtrW  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PtrW-1:0] ptr_o
);

    localparam logic [PtrW-1:0] Last = PtrW'(Depth - 1);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        unique case (1'b1)
            clr_i: ptr_d = '0;
            inc_i: ptr_d = (ptr_q == Last) ? '0 : ptr_q + PtrW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: circular buffer with registered valid/ready.
// Outputs depend only on held state; nothing from the inputs reaches them.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned      Width        = 32,
    parameter int unsigned      Depth        = 2,
    parameter logic [Width-1:0] ResetPayload = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           out_data_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0]  rd_ptr;
    logic [PtrW-1:0]  wr_ptr;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic [Width-1:0] mem_q [Depth];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // Ready comes from the count register alone, so full stays not-ready
    // even when the head is being drained in the same cycle.
    assign push = in_valid_i & ~full & ~flush_i;
    assign pop  = ~empty & out_ready_i & ~flush_i;

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            flush_i:       count_d = '0;
            push & ~pop:   count_d = count_q + CntW'(1);
            pop  & ~push:  count_d = count_q - CntW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= ResetPayload;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= in_data_i;
        end
    end

    pipe_wrap_ctr #(
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_wr_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (push),
        .ptr_o  (wr_ptr)
    );

    pipe_wrap_ctr #(
        .Depth (Depth),
        .PtrW  (PtrW)
    ) u_rd_ctr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (flush_i),
        .inc_i  (pop),
        .ptr_o  (rd_ptr)
    );

    assign in_ready_o  = ~full;
    assign out_valid_o = ~empty;
    assign out_data_o  = mem_q[rd_ptr];
    assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (Depth 2, 3, 4) against
// a queue model, plus directed literal checks.
module tb_pipe_stage_buf;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [2:0] vld = '0;
    logic [2:0] ordy = '0;
    logic [2:0] fl = '0;
    logic [7:0] din [3];
    logic [2:0] irdy;
    logic [2:0] ovld;
    logic [7:0] dout [3];
    logic [1:0] c0;
    logic [1:0] c1;
    logic [2:0] c2;

    int total = 0;
    int bad = 0;

    bq_t q0, q1, q2;
    bq_t got0, got1, got2;

    always #5 clk = ~clk;

    pipe_stage_buf #(.Width(8), .Depth(2), .ResetPayload(8'h00)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[0]),
        .in_valid_i(vld[0]), .in_ready_o(irdy[0]), .in_data_i(din[0]),
        .out_valid_o(ovld[0]), .out_ready_i(ordy[0]), .out_data_o(dout[0]),
        .count_o(c0)
    );

    pipe_stage_buf #(.Width(8), .Depth(3), .ResetPayload(8'h00)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[1]),
        .in_valid_i(vld[1]), .in_ready_o(irdy[1]), .in_data_i(din[1]),
        .out_valid_o(ovld[1]), .out_ready_i(ordy[1]), .out_data_o(dout[1]),
        .count_o(c1)
    );

    pipe_stage_buf #(.Width(8), .Depth(4), .ResetPayload(8'h00)) u_d4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl[2]),
        .in_valid_i(vld[2]), .in_ready_o(irdy[2]), .in_data_i(din[2]),
        .out_valid_o(ovld[2]), .out_ready_i(ordy[2]), .out_data_o(dout[2]),
        .count_o(c2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Queue model: FIFO of accepted bytes, capacity d, flush empties it.
    function automatic bq_t nxt(input bq_t q, input int d, input logic v,
                                input logic r, input logic f,
                                input logic [7:0] x);
        bq_t n;
        int sz;
        n = q;
        sz = q.size();
        if (f) begin
            n.delete();
        end else begin
            if (r && sz != 0) void'(n.pop_front());
            if (v && sz != d) n.push_back(x);
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            q0 = nxt(q0, 2, vld[0], ordy[0], fl[0], din[0]);
            q1 = nxt(q1, 3, vld[1], ordy[1], fl[1], din[1]);
            q2 = nxt(q2, 4, vld[2], ordy[2], fl[2], din[2]);
        end
    end

    task automatic cmpi(input string nm, input bq_t q, input int d,
                        input logic ov, input logic ir, input int c,
                        input logic [7:0] od);
        chk({nm, "_valid"}, int'(ov), int'(q.size() != 0));
        chk({nm, "_ready"}, int'(ir), int'(q.size() != d));
        chk({nm, "_count"}, c, q.size());
        if (q.size() != 0) chk({nm, "_data"}, int'(od), int'(q[0]));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmpi("d2", q0, 2, ovld[0], irdy[0], int'(c0), dout[0]);
            cmpi("d3", q1, 3, ovld[1], irdy[1], int'(c1), dout[1]);
            cmpi("d4", q2, 4, ovld[2], irdy[2], int'(c2), dout[2]);
            if (ovld[0] && ordy[0] && !fl[0]) got0.push_back(dout[0]);
            if (ovld[1] && ordy[1] && !fl[1]) got1.push_back(dout[1]);
            if (ovld[2] && ordy[2] && !fl[2]) got2.push_back(dout[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkq(input string nm, input bq_t g, input bq_t e);
        chk({nm, "_len"}, g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            chk($sformatf("%s_%0d", nm, i), int'(g[i]), int'(e[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bq_t e;
        for (int i = 0; i < 3; i++) din[i] = 8'h00;
        #12;
        rst_n = 1'b1;

        chk("rst_ready", int'(irdy[0]), 1);
        chk("rst_valid", int'(ovld[0]), 0);
        chk("rst_count", int'(c0), 0);
        chk("rst_data", int'(dout[0]), 8'h00);
        chk("rst_data_d4", int'(dout[2]), 8'h00);

        // streaming through depth 2
        tick();
        got0.delete();
        vld[0] = 1'b1; ordy[0] = 1'b1; din[0] = 8'h11;
        tick();
        chk("st_cnt1", int'(c0), 1);
        chk("st_out1", int'(dout[0]), 8'h11);
        din[0] = 8'h22;
        tick();
        chk("st_cnt2", int'(c0), 1);
        chk("st_rdy2", int'(irdy[0]), 1);
        chk("st_out2", int'(dout[0]), 8'h22);
        din[0] = 8'h33;
        tick();
        chk("st_cnt3", int'(c0), 1);
        chk("st_out3", int'(dout[0]), 8'h33);
        vld[0] = 1'b0;
        tick();
        chk("st_cnt_end", int'(c0), 0);
        ordy[0] = 1'b0;
        e = '{8'h11, 8'h22, 8'h33};
        chkq("st_seq", got0, e);

        // back-pressure through depth 3, pointer wrap
        got1.delete();
        vld[1] = 1'b1; din[1] = 8'hA1;
        tick();
        din[1] = 8'hA2;
        tick();
        din[1] = 8'hA3;
        tick();
        din[1] = 8'hA4;
        chk("bp_full_rdy", int'(irdy[1]), 0);
        chk("bp_full_cnt", int'(c1), 3);
        tick();
        chk("bp_hold_cnt", int'(c1), 3);
        chk("bp_hold_out", int'(dout[1]), 8'hA1);
        ordy[1] = 1'b1;
        tick();
        chk("bp_pop1_cnt", int'(c1), 2);
        tick();
        vld[1] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        ordy[1] = 1'b0;
        chk("bp_end_cnt", int'(c1), 0);
        e = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        chkq("bp_seq", got1, e);

        // full with simultaneous pop, depth 2
        got0.delete();
        vld[0] = 1'b1; din[0] = 8'h01;
        tick();
        din[0] = 8'h02;
        tick();
        din[0] = 8'h03; ordy[0] = 1'b1;
        chk("fp_rdy0", int'(irdy[0]), 0);
        tick();
        chk("fp_cnt", int'(c0), 1);
        chk("fp_rdy1", int'(irdy[0]), 1);
        chk("fp_out", int'(dout[0]), 8'h02);
        tick();
        vld[0] = 1'b0;
        tick();
        ordy[0] = 1'b0;
        e = '{8'h01, 8'h02, 8'h03};
        chkq("fp_seq", got0, e);

        // flush with concurrent push and pop
        got0.delete();
        vld[0] = 1'b1; din[0] = 8'h41;
        tick();
        din[0] = 8'h42;
        tick();
        fl[0] = 1'b1; din[0] = 8'h55; ordy[0] = 1'b1;
        tick();
        fl[0] = 1'b0; vld[0] = 1'b0; ordy[0] = 1'b0;
        chk("fl_cnt", int'(c0), 0);
        chk("fl_valid", int'(ovld[0]), 0);
        vld[0] = 1'b1; din[0] = 8'h66;
        tick();
        vld[0] = 1'b0;
        chk("fl_valid2", int'(ovld[0]), 1);
        chk("fl_out2", int'(dout[0]), 8'h66);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        e = '{8'h66};
        chkq("fl_seq", got0, e);

        // asynchronous reset mid-operation, depth 4
        got2.delete();
        vld[2] = 1'b1; din[2] = 8'h71;
        tick();
        din[2] = 8'h72;
        tick();
        din[2] = 8'h73;
        tick();
        vld[2] = 1'b0;
        chk("ar_cnt_pre", int'(c2), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(ovld[2]), 0);
        chk("ar_cnt", int'(c2), 0);
        chk("ar_ready", int'(irdy[2]), 1);
        chk("ar_data", int'(dout[2]), 8'h00);
        #1;
        rst_n = 1'b1;
        tick();
        vld[2] = 1'b1; din[2] = 8'h77; ordy[2] = 1'b1;
        tick();
        vld[2] = 1'b0;
        chk("ar_valid2", int'(ovld[2]), 1);
        chk("ar_out2", int'(dout[2]), 8'h77);
        tick();
        ordy[2] = 1'b0;
        chk("ar_cnt_end", int'(c2), 0);
        e = '{8'h77};
        chkq("ar_seq", got2, e);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
